// File: rtl/adas_pkg.sv
// Shared types for the ADAS emergency-brake sequencer: state encoding and
// a small elaboration-time helper.
package adas_pkg;

  localparam int ADAS_STATE_W = 3;

  typedef enum logic [ADAS_STATE_W-1:0] {
    IDLE    = 3'd0,
    QUALIFY = 3'd1,
    BRAKE   = 3'd2,
    HOLD    = 3'd3,
    FAULT   = 3'd4
  } adas_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/adas_cycle_counter.sv
// Loadable, clearable up-counter with a terminal-compare flag; one instance
// is shared by the qualification and hold phases of the brake sequencer.
module adas_cycle_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         ld,
  input  logic         inc,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] term_val,
  output logic [W-1:0] cnt,
  output logic         at_term
);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_term = (cnt == term_val);

endmodule

// File: rtl/adas_brake_ctrl.sv
// ADAS emergency-brake sequencer: qualifies camera&radar threats, holds the
// brake after release, forces off on error. Option: ADAS_FAULT_LATCH_EN.
module adas_brake_ctrl
  import adas_pkg::*;
#(
  parameter int DETECT_CYCLES = 4,
  parameter int HOLD_CYCLES   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    driver_break,
  input  logic                    camera,
  input  logic                    radar,
  input  logic                    adas_error,
  input  logic                    fault_clear,
  output logic                    vehicle_break,
  output logic                    adas_active,
  output logic                    adas_fault,
  output logic [ADAS_STATE_W-1:0] state
);

  localparam int               CNT_W       = $clog2(max_int(DETECT_CYCLES, HOLD_CYCLES));
  localparam logic [CNT_W-1:0] DETECT_TERM = CNT_W'(DETECT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_TERM   = CNT_W'(HOLD_CYCLES - 1);

  adas_state_t      cur_state;
  logic             threat;
  logic             fault_exit;
  logic             cnt_clr;
  logic             cnt_ld;
  logic             cnt_inc;
  logic [CNT_W-1:0] term_val;
  logic [CNT_W-1:0] cnt;
  logic             at_term;

  assign threat = camera & radar;

`ifdef ADAS_FAULT_LATCH_EN
  // Error is already handled first, so only the acknowledge is needed here.
  assign fault_exit = fault_clear;
`else
  logic unused_fault_clear;
  assign unused_fault_clear = fault_clear;
  assign fault_exit         = 1'b1;
`endif

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    cnt_clr  = 1'b0;
    cnt_ld   = 1'b0;
    cnt_inc  = 1'b0;
    term_val = HOLD_TERM;
    if (adas_error) begin
      cnt_clr = 1'b1;
    end else begin
      case (cur_state)
        IDLE:    cnt_ld = threat;
        QUALIFY: begin
          term_val = DETECT_TERM;
          if (!threat)       cnt_clr = 1'b1;
          else if (!at_term) cnt_inc = 1'b1;
        end
        BRAKE:   cnt_clr = ~threat;
        HOLD: begin
          if (!threat) begin
            if (at_term) cnt_clr = 1'b1;
            else         cnt_inc = 1'b1;
          end
        end
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  adas_cycle_counter #(.W(CNT_W)) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr),
    .ld       (cnt_ld),
    .inc      (cnt_inc),
    .ld_val   (CNT_W'(1)),
    .term_val (term_val),
    .cnt      (cnt),
    .at_term  (at_term)
  );

  // Status flags are registered alongside the state so they change on the
  // same edge as the transition that implies them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur_state   <= IDLE;
      adas_active <= 1'b0;
      adas_fault  <= 1'b0;
    end else if (adas_error) begin
      cur_state   <= FAULT;
      adas_active <= 1'b0;
      adas_fault  <= 1'b1;
    end else begin
      case (cur_state)
        IDLE: begin
          if (threat) cur_state <= QUALIFY;
        end
        QUALIFY: begin
          if (!threat) begin
            cur_state <= IDLE;
          end else if (at_term) begin
            cur_state   <= BRAKE;
            adas_active <= 1'b1;
          end
        end
        BRAKE: begin
          if (!threat) cur_state <= HOLD;
        end
        HOLD: begin
          if (threat) begin
            cur_state <= BRAKE;
          end else if (at_term) begin
            cur_state   <= IDLE;
            adas_active <= 1'b0;
          end
        end
        FAULT: begin
          if (fault_exit) begin
            cur_state  <= IDLE;
            adas_fault <= 1'b0;
          end
        end
        default: begin
          cur_state   <= FAULT;
          adas_active <= 1'b0;
          adas_fault  <= 1'b1;
        end
      endcase
    end
  end

  assign state         = cur_state;
  assign vehicle_break = driver_break | adas_active;

endmodule

// File: tb/tb_adas_brake_ctrl.sv
// Self-checking bench for adas_brake_ctrl: vector table plus hand-written
// hold, fault, driver-override and mid-operation reset sequences.
module tb_adas_brake_ctrl;

`ifdef ADAS_FAULT_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       driver_break, camera, radar, adas_error, fault_clear;
  logic       vehicle_break, adas_active, adas_fault;
  logic [2:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit         drv, cam, rad, err, fclr;
    logic [2:0] st;
    bit         act, flt;
    string      name;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    bit         act, flt, vb;
    string      name;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  adas_brake_ctrl #(.DETECT_CYCLES(4), .HOLD_CYCLES(16)) dut (
    .clock         (clock),
    .reset         (reset),
    .driver_break  (driver_break),
    .camera        (camera),
    .radar         (radar),
    .adas_error    (adas_error),
    .fault_clear   (fault_clear),
    .vehicle_break (vehicle_break),
    .adas_active   (adas_active),
    .adas_fault    (adas_fault),
    .state         (state)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mk(input bit drv, cam, rad, err, fclr,
                              input logic [2:0] st, input bit act, flt,
                              input string name);
    vec_t v;
    v.drv = drv; v.cam = cam; v.rad = rad; v.err = err; v.fclr = fclr;
    v.st = st; v.act = act; v.flt = flt; v.name = name;
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare after the edge.
  task automatic apply(input vec_t v);
    exp_t e;
    driver_break = v.drv;
    camera       = v.cam;
    radar        = v.rad;
    adas_error   = v.err;
    fault_clear  = v.fclr;
    sb.push_back('{st: v.st, act: v.act, flt: v.flt, vb: v.drv | v.act, name: v.name});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check({e.name, " state"}, 32'(state), 32'(e.st));
    check({e.name, " active"}, 32'(adas_active), 32'(e.act));
    check({e.name, " fault"}, 32'(adas_fault), 32'(e.flt));
    check({e.name, " vbreak"}, 32'(vehicle_break), 32'(e.vb));
  endtask

  task automatic step(input bit drv, cam, rad, err, fclr,
                      input logic [2:0] st, input bit act, flt, input string name);
    apply(mk(drv, cam, rad, err, fclr, st, act, flt, name));
  endtask

  task automatic reach_brake(input string tag);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 3'd1, 0, 0, {tag, " qual"});
    step(0, 1, 1, 0, 0, 3'd2, 1, 0, {tag, " brake"});
  endtask

  task automatic release_full(input string tag);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0, 3'd3, 1, 0, {tag, " hold"});
    step(0, 0, 0, 0, 0, 3'd0, 0, 0, {tag, " hold end"});
  endtask

  initial begin
    reset = 1'b1;
    driver_break = 0; camera = 0; radar = 0; adas_error = 0; fault_clear = 0;

    // Reset values and driver override while in reset.
    #2;
    check("rst state", 32'(state), 32'd0);
    check("rst active", 32'(adas_active), 32'd0);
    check("rst fault", 32'(adas_fault), 32'd0);
    check("rst vbreak low", 32'(vehicle_break), 32'd0);
    driver_break = 1'b1;
    #1;
    check("rst vbreak drv", 32'(vehicle_break), 32'd1);
    driver_break = 1'b0;
    #19;
    reset = 1'b0;

    // Vector table: detection, hold re-entry, fault priority, restart.
    tbl.push_back(mk(0, 1, 0, 0, 0, 3'd0, 0, 0, "cam only"));
    tbl.push_back(mk(0, 0, 1, 0, 0, 3'd0, 0, 0, "radar only"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "det 1"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "det 2"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "det 3"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd2, 1, 0, "det 4"));
    tbl.push_back(mk(1, 1, 1, 0, 0, 3'd2, 1, 0, "brake drv"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd3, 1, 0, "release"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd2, 1, 0, "rethreat"));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3'd3, 1, 0, "release 2"));
    tbl.push_back(mk(1, 1, 1, 1, 0, 3'd4, 0, 1, "err in hold"));
    tbl.push_back(mk(1, 0, 0, 0, 0, LATCH ? 3'd4 : 3'd0, 0, LATCH, "err gone"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd0, 0, 0, "clear"));
    tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "qual again"));
    tbl.push_back(mk(0, 1, 1, 1, 0, 3'd4, 0, 1, "err+threat"));
    tbl.push_back(mk(0, 0, 0, 1, 1, 3'd4, 0, 1, "clear w err"));
    tbl.push_back(mk(0, 0, 0, 0, 1, 3'd0, 0, 0, "clear ok"));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "rst q1"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "rst q2"));
      tbl.push_back(mk(0, 1, 1, 0, 0, 3'd1, 0, 0, "rst q3"));
      tbl.push_back(mk(0, 0, 0, 0, 0, 3'd0, 0, 0, "rst gap"));
    end
    foreach (tbl[i]) apply(tbl[i]);

    // Full hold length after release.
    reach_brake("A");
    release_full("A");

    // Threat returns at hold cycle 10; the next release restarts the hold.
    reach_brake("B");
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 3'd3, 1, 0, "B hold");
    step(0, 1, 1, 0, 0, 3'd2, 1, 0, "B rebrake");
    release_full("B");

    // One-cycle error pulse during BRAKE, driver override while faulted.
    reach_brake("C");
    step(0, 1, 1, 1, 0, 3'd4, 0, 1, "C err");
    driver_break = 1'b1;
    #1;
    check("C fault drv vbreak", 32'(vehicle_break), 32'd1);
    driver_break = 1'b0;
    #1;
    check("C fault vbreak low", 32'(vehicle_break), 32'd0);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, LATCH ? 3'd4 : 3'd0, 0, LATCH, "C after err");
    step(0, 0, 0, 0, 1, 3'd0, 0, 0, "C ack");

    // Asynchronous reset mid-HOLD, then full requalification.
    reach_brake("D");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 3'd3, 1, 0, "D hold");
    #2;
    reset = 1'b1;
    #1;
    check("D rst state", 32'(state), 32'd0);
    check("D rst active", 32'(adas_active), 32'd0);
    check("D rst vbreak", 32'(vehicle_break), 32'd0);
    driver_break = 1'b1;
    #1;
    check("D rst drv vbreak", 32'(vehicle_break), 32'd1);
    @(posedge clock);
    #1;
    check("D rst held state", 32'(state), 32'd0);
    driver_break = 1'b0;
    reset = 1'b0;
    reach_brake("D requal");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adas_brake_ctrl.md
# adas_brake_ctrl

Sequencing controller for the ADAS emergency-brake path. It qualifies combined camera and radar detections over several consecutive cycles before braking. It holds the brake for a minimum time after the threat clears and forces the ADAS path off on error. It sits between the raw sensor and error signals and the engine brake line, and produces the final `vehicle_break`. The driver brake always overrides with zero latency.

## Interface
Parameters:
- `DETECT_CYCLES`, default 4: consecutive sampled threat cycles required before ADAS braking; legal range ≥ 2.
- `HOLD_CYCLES`, default 16: cycles the ADAS brake is held after the threat disappears; legal range ≥ 1.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high reset. One clock domain, asynchronous active-high reset.
- `driver_break`  in  1  brake pedal signal.
- `camera`  in  1  object in front of the vehicle.
- `radar`  in  1  object approaching the vehicle.
- `adas_error`  in  1  ADAS error indication.
- `fault_clear`  in  1  fault acknowledge; used only with `ADAS_FAULT_LATCH_EN`.
- `vehicle_break`  out  1  brake signal to the engine.
- `adas_active`  out  1  ADAS is currently braking (state BRAKE or HOLD).
- `adas_fault`  out  1  controller is in state FAULT.
- `state`  out  3  current FSM encoding, for debug.

## Operation
- threat = `camera & radar`. All inputs are sampled on rising `clock`.
- States and encodings: IDLE=0, QUALIFY=1, BRAKE=2, HOLD=3, FAULT=4. Encodings 5–7 are illegal and go to FAULT.
- Priority rule: if `adas_error` = 1 at an edge, the next state is FAULT from any state. This overrides every transition below.
- IDLE:
  - threat=1 → QUALIFY, and `cnt` is set to 1.
  - Otherwise stay in IDLE.
- QUALIFY:
  - threat=0 → IDLE, and `cnt` is cleared.
  - threat=1 and `cnt` = `DETECT_CYCLES`-1 → BRAKE.
  - Otherwise `cnt`++.
- BRAKE:
  - threat=1 → stay in BRAKE.
  - threat=0 → HOLD, and `cnt` is set to 0.
- HOLD:
  - threat=1 → BRAKE.
  - threat=0 and `cnt` = `HOLD_CYCLES`-1 → IDLE.
  - Otherwise `cnt`++.
- FAULT: exit condition depends on configuration; the exit always goes to IDLE with `cnt` = 0.
- Outputs:
  - `adas_active` = (state==BRAKE || state==HOLD), decoded from the registered state.
  - `vehicle_break` = `driver_break` | `adas_active`. This is combinational from `driver_break`.
- Width rules:
  - `cnt` width is $clog2(max(`DETECT_CYCLES`, `HOLD_CYCLES`)).
  - The counter never wraps, because every terminal compare forces a state exit.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `adas_active` = 0, `adas_fault` = 0, `state` = 0.
  - `vehicle_break` = `driver_break`.
- Detection latency: with threat high on edges k … k+`DETECT_CYCLES`-1, `adas_active` rises right after edge k+`DETECT_CYCLES`-1.
- A single low sample during QUALIFY restarts qualification.
- Release: threat falls, first sampled low at edge m → `adas_active` falls right after edge m+`HOLD_CYCLES`.
- Fault reaction: `adas_error` sampled at edge f → `adas_active` = 0 and `adas_fault` = 1 right after edge f. This is one-edge latency from any state.
- Error and threat on the same edge: FAULT wins.
- Driver brake: zero-cycle path, independent of state, reset and fault.
- Reset asserted mid-operation: all state is cleared immediately and asynchronously. `vehicle_break` still follows `driver_break`.

## Configuration
- Macro: `ADAS_FAULT_LATCH_EN`.
- Defined:
  - FAULT is latched.
  - Exit to IDLE requires `adas_error`=0 and `fault_clear`=1 on the same edge.
  - `fault_clear` while `adas_error`=1 is ignored.
- Undefined:
  - FAULT exits to IDLE on the first edge with `adas_error`=0.
  - `fault_clear` is ignored.

## Structure
- Shared package `adas_pkg`:
  - `adas_state_t` enum with the encodings above.
  - `ADAS_STATE_W` = 3.
- The existing combinational ADAS module stays unchanged. This block replaces it in the top-level brake path.
- One sub-module, `adas_cycle_counter`: a loadable, clearable up-counter with a terminal-compare output, shared by QUALIFY and HOLD.

## Test plan
- Threat high 4 cycles, default params → `adas_active` rises after the 4th edge, and `state` goes 1 → 2.
- Threat high 3 cycles, low 1 cycle, high 3 cycles → `adas_active` never asserts, and `state` returns to 0 after each low sample.
- BRAKE reached, then threat low → `vehicle_break` stays 1 for exactly 16 cycles, then 0. Threat re-asserted at hold cycle 10 → state returns to BRAKE and the hold restarts on the next release.
- `adas_error` pulsed for 1 cycle during BRAKE → `vehicle_break` = 0 after one edge and `adas_fault` = 1.
  - Without the macro: IDLE on the next edge.
  - With the macro: stays in FAULT until `fault_clear`=1 with `adas_error`=0.
- `driver_break`=1 while in reset and while in FAULT → `vehicle_break`=1 in the same cycle.
- `reset` asserted mid-HOLD → outputs clear immediately, and the next threat needs full qualification.
